// File: rtl/param_shift_unit.sv
// Word register with parallel load, barrel shift/rotate by a variable amount,
// and a counted serial exchange that shifts the word out LSB-first while shifting ser_in in.
module param_shift_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic [SHW-1:0]   amt,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SER} state_t;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_SLL  = 3'd2;
    localparam logic [2:0] OP_SRL  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;
    localparam logic [2:0] OP_SER  = 3'd7;

    localparam logic [SHW:0]   WLIM = (SHW+1)'(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH-1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             ovr;
    int               rot;
    logic [WIDTH-1:0] sll_r, srl_r, rol_r, ror_r, sra_r;

    // Amounts >= WIDTH only occur when WIDTH is not a power of two.
    assign ovr   = {1'b0, amt} >= WLIM;
    assign rot   = int'(amt) % WIDTH;
    assign sll_r = ovr ? '0 : q_q << amt;
    assign srl_r = ovr ? '0 : q_q >> amt;
    assign rol_r = (q_q << rot) | (q_q >> (WIDTH - rot));
    assign ror_r = (q_q >> rot) | (q_q << (WIDTH - rot));
    assign sra_r = ovr ? {WIDTH{q_q[WIDTH-1]}} : WIDTH'($signed(q_q) >>> amt);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = (op != OP_SER);
                    case (op)
                        OP_HOLD: q_d = q_q;
                        OP_LOAD: q_d = d;
                        OP_SLL:  q_d = sll_r;
                        OP_SRL:  q_d = srl_r;
                        OP_ROL:  q_d = rol_r;
                        OP_ROR:  q_d = ror_r;
                        OP_SRA:  q_d = sra_r;
                        default: begin
                            cnt_d   = '0;
                            state_d = SER;
                        end
                    endcase
                end
            end
            SER: begin
                q_d   = {ser_in, q_q[WIDTH-1:1]};
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q       = q_q;
    assign busy    = (state_q == SER);
    assign ser_out = busy & q_q[0];
    assign done    = done_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// Directed bench for param_shift_unit at WIDTH=8; expected words and serial bits go
// through scoreboard queues filled at drive time and drained when the DUT responds.
module tb_param_shift_unit;

    localparam int W = 8;
    localparam int S = $clog2(W);

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] d = '0;
    logic [S-1:0] amt = '0;
    logic         ser_in = 1'b0;
    logic [W-1:0] q;
    logic         ser_out, busy, done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q_exp[$];
    logic         bit_exp[$];

    param_shift_unit #(.WIDTH(W)) dut (
        .clk(clk), .res(res), .start(start), .op(op), .d(d), .amt(amt),
        .ser_in(ser_in), .q(q), .ser_out(ser_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one IDLE command; q and done are checked one cycle later.
    task automatic cmd(input string tag, input logic [2:0] o, input logic [W-1:0] dv,
                       input logic [S-1:0] a, input logic [W-1:0] eq);
        @(negedge clk);
        start = 1'b1; op = o; d = dv; amt = a;
        q_exp.push_back(eq);
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_q"}, 32'(q), 32'(q_exp.pop_front()));
    endtask

    // Full serial exchange; optionally pulses a LOAD while busy.
    task automatic ser(input string tag, input logic [W-1:0] rx, input bit inject);
        logic [W-1:0] word;
        word = q;
        for (int k = 0; k < W; k++) bit_exp.push_back(word[k]);
        q_exp.push_back(rx);
        @(negedge clk);
        start = 1'b1; op = 3'd7; d = 8'h5A; amt = 3'd2;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            chk({tag, "_serout"}, 32'(ser_out), 32'(bit_exp.pop_front()));
            ser_in = rx[k];
            if (inject) begin
                start = (k == 2);
                op = 3'd1; d = 8'hFF;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_done_end"}, 32'(done), 32'd1);
        chk({tag, "_serout_idle"}, 32'(ser_out), 32'd0);
        chk({tag, "_q"}, 32'(q), 32'(q_exp.pop_front()));
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_serout", 32'(ser_out), 32'd0);
        @(negedge clk);
        res = 1'b1;

        cmd("load_a5", 3'd1, 8'hA5, 3'd0, 8'hA5);
        @(negedge clk);
        chk("load_done_pulse", 32'(done), 32'd0);
        chk("hold_idle_q", 32'(q), 32'hA5);

        cmd("load96a", 3'd1, 8'h96, 3'd0, 8'h96);
        cmd("sll3", 3'd2, 8'h00, 3'd3, 8'hB0);
        cmd("load96b", 3'd1, 8'h96, 3'd0, 8'h96);
        cmd("srl3", 3'd3, 8'h00, 3'd3, 8'h12);
        cmd("load96c", 3'd1, 8'h96, 3'd0, 8'h96);
        cmd("sra3", 3'd6, 8'h00, 3'd3, 8'hF2);
        cmd("sra7", 3'd6, 8'h00, 3'd7, 8'hFF);

        cmd("load81a", 3'd1, 8'h81, 3'd0, 8'h81);
        cmd("rol1", 3'd4, 8'h00, 3'd1, 8'h03);
        cmd("load81b", 3'd1, 8'h81, 3'd0, 8'h81);
        cmd("ror1", 3'd5, 8'h00, 3'd1, 8'hC0);
        cmd("rol0", 3'd4, 8'h00, 3'd0, 8'hC0);
        cmd("sll0", 3'd2, 8'h00, 3'd0, 8'hC0);
        cmd("hold", 3'd0, 8'h11, 3'd5, 8'hC0);
        cmd("ror3", 3'd5, 8'h00, 3'd3, 8'h18);
        cmd("sll7", 3'd2, 8'h00, 3'd7, 8'h00);

        cmd("loadc5", 3'd1, 8'hC5, 3'd0, 8'hC5);
        ser("ser_c5", 8'h4D, 1'b0);

        cmd("load3c", 3'd1, 8'h3C, 3'd0, 8'h3C);
        ser("ser_inj", 8'hE1, 1'b1);

        cmd("load6b", 3'd1, 8'h6B, 3'd0, 8'h6B);
        @(negedge clk);
        start = 1'b1; op = 3'd7; ser_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #2 res = 1'b0;
        #1;
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_serout", 32'(ser_out), 32'd0);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        cmd("post_rst_load", 3'd1, 8'h3C, 3'd0, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
